// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain stage for the async FIFO, living entirely in the rd_clk
// domain. It turns the FIFO's empty / rd_en / data_out interface into a
// valid/ready stream. Read data lands in a small circular skid buffer, so
// the stream keeps one word per cycle even though the issue decision
// cannot see out_ready.
//
// Optional feature macro: FIFO_RD_STATS_EN
//   When defined, adds the rd_count and stall_count statistics outputs.
//
// Parameters:
//   Data_Width  width of FIFO read data and stream data
//   SKID_DEPTH  buffer entries; must be at least 3 for full throughput
//   CNT_WIDTH   width of the statistics counters (stats build only)
//
// Ports:
//   rd_clk       read-domain clock
//   rd_rstn      asynchronous active-low reset
//   empty        FIFO empty flag (rd_clk domain)
//   data_out     FIFO read data, valid the cycle after rd_en
//   rd_en        FIFO read request
//   flush        synchronous drop of buffered and in-flight words
//   out_valid    stream word available
//   out_ready    downstream accepts the word
//   out_data     stream word (head of the buffer)
//   level        occupied buffer entries
//   rd_count     words delivered (stats build only)
//   stall_count  cycles with out_ready && !out_valid (stats build only)
//
// Handshake: a word transfers on a cycle where out_valid && out_ready are
// both high. Once out_valid is raised, out_valid and out_data stay stable
// until that transfer happens; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int Data_Width = 8,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              rd_clk,
    input  logic                              rd_rstn,
    input  logic                              empty,
    input  logic [Data_Width-1:0]             data_out,
    output logic                              rd_en,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [Data_Width-1:0]             out_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   level
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]              rd_count,
    output logic [CNT_WIDTH-1:0]              stall_count
`endif
);

    localparam int LVL_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);
    localparam logic [LVL_W:0]   DEPTH_V  = (LVL_W + 1)'(SKID_DEPTH);

    logic [Data_Width-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  inflight;
    logic                  running;
    logic                  push;
    logic                  pop;
    logic [LVL_W:0]        occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // The word requested last cycle is on data_out now; flush discards it.
    assign push      = inflight && !flush;

    // Count the outstanding read as occupied so a full buffer can never be
    // overrun, whatever out_ready does in the meantime. With three entries
    // one buffered word plus one in flight still leaves room to issue, which
    // is what keeps the stream at one word per cycle.
    assign occupancy = {1'b0, level} + {{LVL_W{1'b0}}, inflight};

    // running holds off reads until the first edge after reset release, so
    // the FIFO is never read on a partially released reset.
    assign rd_en = running && !empty && !flush && (occupancy < DEPTH_V);

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            running  <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            running  <= 1'b1;
            inflight <= rd_en;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= data_out;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    // Statistics survive flush; only reset clears them. Both wrap naturally.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_count    <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            if (out_ready && !out_valid) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    // Keeps CNT_WIDTH referenced in the build without statistics.
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Bench for fifo_rd_stream. A behavioural FIFO feeds the DUT: words loaded
// into it are also pushed onto exp_q, and a negedge monitor pops exp_q and
// compares on every stream transfer. After a flush, words that were read
// from the FIFO but never delivered are trimmed from exp_q. Issue-rule
// vectors come from a table; multi-cycle corners are hand-written sequences.
// Statistics checks are compiled in when FIFO_RD_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int         SKID_DEPTH = 3;
    localparam logic [1:0] FULL_LVL   = 2'd3;

    logic       rd_clk;
    logic       rd_rstn;
    logic       empty;
    logic [7:0] data_out;
    logic       rd_en;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] level;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] stall_count;
`endif

    fifo_rd_stream dut (
        .rd_clk      (rd_clk),
        .rd_rstn     (rd_rstn),
        .empty       (empty),
        .data_out    (data_out),
        .rd_en       (rd_en),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count    (rd_count),
        .stall_count (stall_count)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural FIFO ----------------
    logic [7:0] fifo_mem [0:4095];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    logic       fifo_clr;
    logic       force_empty;

    assign empty = force_empty || (fifo_rd == fifo_wr);

    always @(posedge rd_clk) begin
        if (fifo_clr) begin
            fifo_rd <= fifo_wr;
        end else if (rd_en) begin
            data_out <= fifo_mem[fifo_rd];
            fifo_rd  <= fifo_rd + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_checks   = 0;
    int n_errors   = 0;
    int exp_stalls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] v);
        fifo_mem[fifo_wr] = v;
        fifo_wr++;
        exp_q.push_back(v);
    endtask

    task automatic do_reset(input logic ready);
        rd_rstn     = 1'b0;
        flush       = 1'b0;
        force_empty = 1'b0;
        out_ready   = ready;
        fifo_clr    = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_stalls = 0;
        fifo_clr   = 1'b0;
        rd_rstn    = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_done", exp_q.size(), 0);
        tick();
        check("drain_level", level, 0);
    endtask

    task automatic monitor_loop();
        logic       hold_prev;
        logic [7:0] hold_data;
        logic       flush_seen;
        logic       rd_en_prev;
        logic [7:0] exp_v;
        int         remaining;
        hold_prev  = 1'b0;
        hold_data  = '0;
        flush_seen = 1'b0;
        rd_en_prev = 1'b0;
        forever begin
            @(negedge rd_clk);
            if (!rd_rstn) begin
                hold_prev  = 1'b0;
                flush_seen = 1'b0;
                rd_en_prev = 1'b0;
            end else begin
                // Words read from the FIFO but not delivered by the flush are gone.
                if (flush_seen) begin
                    remaining = fifo_wr - fifo_rd;
                    while (exp_q.size() > remaining) void'(exp_q.pop_front());
                end
                flush_seen = flush;
                if (out_ready && !out_valid) exp_stalls++;
                if (hold_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hold_data);
                end
                hold_prev = out_valid && !out_ready && !flush;
                hold_data = out_data;
                if (out_valid && out_ready) begin
                    check("queue_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        check("stream_data", out_data, exp_v);
                    end
                end
                if (empty) check("rd_en_while_empty", rd_en, 0);
                if (rd_en_prev && !flush) check("push_into_full", level == FULL_LVL, 0);
                rd_en_prev = rd_en;
            end
        end
    endtask

    // ---------------- issue-rule table ----------------
    typedef struct {
        int   fill;
        logic emp;
        logic fl;
        logic exp_rd_en;
        int   exp_level;
        logic exp_valid;
    } vec_t;

    vec_t vecs [8];
    int   bubbles;

    initial begin
        rd_rstn     = 1'b0;
        flush       = 1'b0;
        force_empty = 1'b0;
        out_ready   = 1'b0;
        fifo_clr    = 1'b1;
        data_out    = '0;

        vecs[0] = '{fill: 0, emp: 1'b0, fl: 1'b0, exp_rd_en: 1'b1, exp_level: 0, exp_valid: 1'b0};
        vecs[1] = '{fill: 1, emp: 1'b0, fl: 1'b0, exp_rd_en: 1'b1, exp_level: 1, exp_valid: 1'b1};
        vecs[2] = '{fill: 2, emp: 1'b0, fl: 1'b0, exp_rd_en: 1'b1, exp_level: 2, exp_valid: 1'b1};
        vecs[3] = '{fill: 3, emp: 1'b0, fl: 1'b0, exp_rd_en: 1'b0, exp_level: 3, exp_valid: 1'b1};
        vecs[4] = '{fill: 2, emp: 1'b1, fl: 1'b0, exp_rd_en: 1'b0, exp_level: 2, exp_valid: 1'b1};
        vecs[5] = '{fill: 0, emp: 1'b1, fl: 1'b0, exp_rd_en: 1'b0, exp_level: 0, exp_valid: 1'b0};
        vecs[6] = '{fill: 1, emp: 1'b0, fl: 1'b1, exp_rd_en: 1'b0, exp_level: 1, exp_valid: 1'b1};
        vecs[7] = '{fill: 3, emp: 1'b1, fl: 1'b1, exp_rd_en: 1'b0, exp_level: 3, exp_valid: 1'b1};

        fork
            monitor_loop();
        join_none

        // ---- reset check ----
        tick();
        fifo_clr  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) load_word(8'(8'h10 + k));
        tick();
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_out_data", out_data, 0);
        rd_rstn = 1'b1;
        tick();
        check("rel_first_rd_en", rd_en, 1);
        tick();
        check("rel_valid_early", out_valid, 0);
        tick();
        check("rel_valid_latency", out_valid, 1);
        wait_drain(50);

        // ---- table-driven issue rule ----
        for (int v = 0; v < 8; v++) begin
            do_reset(1'b0);
            for (int k = 0; k < vecs[v].fill; k++) load_word(8'(8'h40 + v * 8 + k));
            for (int k = 0; k < 5; k++) tick();
            for (int k = 0; k < 5; k++) load_word(8'(8'h80 + v * 8 + k));
            force_empty = vecs[v].emp;
            flush       = vecs[v].fl;
            #1;
            check($sformatf("vec%0d_rd_en", v), rd_en, vecs[v].exp_rd_en);
            check($sformatf("vec%0d_level", v), level, vecs[v].exp_level);
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].exp_valid);
            tick();
            flush       = 1'b0;
            force_empty = 1'b0;
            out_ready   = 1'b1;
            wait_drain(100);
        end

        // ---- single word ----
        do_reset(1'b1);
        load_word(8'hA5);
        #1;
        check("single_rd_en", rd_en, 1);
        tick();
        check("single_rd_en_off", rd_en, 0);
        check("single_valid_t1", out_valid, 0);
        tick();
        check("single_valid_t2", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        check("single_level", level, 1);
        tick();
        check("single_level_after", level, 0);
        check("single_valid_after", out_valid, 0);
        check("single_queue_empty", exp_q.size(), 0);

        // ---- full rate ----
        do_reset(1'b1);
        for (int k = 0; k < 256; k++) load_word(8'(k));
        for (int k = 0; k < 10; k++) begin
            if (out_valid) break;
            tick();
        end
        bubbles = 0;
        for (int k = 0; k < 256; k++) begin
            if (!out_valid) bubbles++;
            tick();
        end
        check("full_rate_bubbles", bubbles, 0);
        check("full_rate_all_delivered", exp_q.size(), 0);
        wait_drain(20);

        // ---- backpressure ----
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) load_word(8'(k * 7 + 3));
        for (int k = 0; k < 10; k++) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("bp_level", level, 3);
        check("bp_rd_en", rd_en, 0);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain(100);

        // ---- flush with a read in flight ----
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) load_word(8'(8'h30 + k));
        #1;
        check("flush_rd_en_t", rd_en, 1);
        tick();
        flush = 1'b1;
        #1;
        check("flush_rd_en_forced", rd_en, 0);
        tick();
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) break;
            tick();
        end
        check("flush_next_word", out_data, 8'h31);
        wait_drain(50);

`ifdef FIFO_RD_STATS_EN
        // ---- statistics ----
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) load_word(8'(8'hC0 + k));
        wait_drain(50);
        for (int k = 0; k < 4; k++) tick();
        check("stats_rd_count", rd_count, 5);
        check("stats_stall_min", stall_count >= 16'd4, 1);
        check("stats_stall_model", stall_count, exp_stalls);
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("stats_rd_count_flush", rd_count, 5);
        check("stats_stall_flush", stall_count, exp_stalls);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage downstream of the async FIFO top, in the rd_clk domain.
- Converts the FIFO's empty / rd_en / data_out interface into a valid/ready stream for downstream logic.
- Holds read data in a small skid buffer so the stream sustains one word per cycle under backpressure.
- Never under-reads or over-reads the FIFO.

Parameters:
- Data_Width, 8, width of FIFO read data and stream data.
- SKID_DEPTH, 3, output buffer entries; legal minimum 3, which is required for full throughput.
- CNT_WIDTH, 16, width of the statistics counters; used only with FIFO_RD_STATS_EN.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rstn  in  1  asynchronous active-low reset.
- empty  in  1  FIFO empty flag, registered in the rd_clk domain.
- data_out  in  Data_Width  FIFO read data; valid in the cycle after rd_en is high.
- rd_en  out  1  FIFO read request.
- flush  in  1  synchronous drop of all buffered and in-flight words.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  Data_Width  stream word, taken from the head of the buffer.
- level  out  $clog2(SKID_DEPTH+1)  number of occupied buffer entries.
- rd_count  out  CNT_WIDTH  words delivered; present only with FIFO_RD_STATS_EN.
- stall_count  out  CNT_WIDTH  underrun cycles; present only with FIFO_RD_STATS_EN.

Behaviour:
- Reset (async, rd_rstn=0):
  - rd_en=0, out_valid=0, out_data=0, level=0.
  - In-flight flag=0.
  - Buffer pointers=0; counters=0.
- In-flight flag: register equal to the previous cycle's rd_en.
  - When set, data_out is captured into the buffer tail at the next rd_clk edge.
- Issue rule:
  - rd_en = !empty && !flush && (level + inflight < SKID_DEPTH).
  - Combinational from registered state and empty only; it never depends on out_ready.
- Latency: empty falls in cycle t → rd_en=1 in t → data_out valid in t+1 → out_valid=1 in t+2.
- Handshake:
  - A word transfers when out_valid && out_ready.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Buffer: circular, SKID_DEPTH entries, FIFO order preserved.
  - Push (capture) and pop (transfer) in the same cycle → level unchanged.
- Throughput: with out_ready tied high and empty low, rd_en stays high every cycle and out_valid stays high every cycle after the initial 2-cycle latency.
- Backpressure: with out_ready low, at most SKID_DEPTH words are accepted.
  - rd_en deasserts once level + inflight reaches SKID_DEPTH.
  - No word is lost or duplicated.
- Overflow is impossible by construction. Asserting a push while level==SKID_DEPTH is a bench assertion failure.
- empty rising while a read is in flight: the in-flight word is still captured; no further rd_en.
- flush (sync, one or more cycles):
  - Next edge: level=0, out_valid=0, pointers cleared.
  - A word in flight in the flush cycle is discarded.
  - rd_en is forced to 0 during flush.
  - A transfer in the flush cycle still completes, since out_valid was already high.
- Reset mid-stream: all state cleared immediately; in-flight data is not captured.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- Defined:
  - rd_count increments on every transfer.
  - stall_count increments on every cycle with out_ready && !out_valid.
  - Both counters wrap at 2^CNT_WIDTH, are cleared by reset, and are not cleared by flush.
- Undefined: rd_count and stall_count ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rd_rstn=0 with empty=0 and out_ready=1 → rd_en=0, out_valid=0, level=0. Release rd_rstn → first rd_en in the cycle after release; out_valid 2 cycles later.
- Single word: FIFO holds 0xA5, empty falls in cycle 10 → rd_en in 10 only, out_valid=1 with out_data=0xA5 in cycle 12, empty rises in 11 → one transfer, level returns to 0.
- Full rate: 256 words 0x00..0xFF, out_ready=1 → 256 consecutive transfers in order, no bubbles after the first, no rd_en while empty=1.
- Backpressure: stream running, out_ready low for 10 cycles → level reaches 3 and rd_en goes low. out_ready high → words continue in order with no gap or duplicate.
- Flush with in-flight read: rd_en=1 in cycle t, flush=1 in t+1 → in cycle t+2 level=0 and out_valid=0; the next delivered word is the next FIFO entry, and the in-flight word is dropped.
- With FIFO_RD_STATS_EN: 5 transfers, then 4 cycles with out_ready=1 and empty=1 → rd_count=5, stall_count≥4; a flush leaves both counters unchanged.
